// File: rtl/pc_gen_pkg.sv
// pc_pkg: shared state encoding and redirect-select codes for the fetch PC generator
package pc_pkg;
  typedef enum logic [2:0] {BOOT, RUN, FLUSH, WAIT_TRAP, HALT} pc_state_e;
  localparam logic [1:0] SEL_BR   = 2'b00;
  localparam logic [1:0] SEL_JALR = 2'b10;
  localparam logic [1:0] SEL_TRAP = 2'b01;
  localparam logic [1:0] SEL_MRET = 2'b11;
endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch handshake toward the IFU plus the redirect bus from EXU/trap unit
interface pc_gen_if #(parameter int WIDTH = 32);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_pc;
  logic             fetch_is16;
  logic             redirect_valid;
  logic [1:0]       redirect_sel;
  logic [WIDTH-1:0] br_pc;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] mtvec;
  logic [WIDTH-1:0] mepc;
  modport master (output out_valid, out_pc,
                  input out_ready, fetch_is16, redirect_valid, redirect_sel, br_pc, rs1, imm, mtvec, mepc);
  modport slave (input out_valid, out_pc,
                 output out_ready, fetch_is16, redirect_valid, redirect_sel, br_pc, rs1, imm, mtvec, mepc);
endinterface

// File: rtl/pc_gen_target_calc.sv
// pc_target_calc: redirect target mux with low-bit clearing and alignment check
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter bit C_EXT = 1'b0
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] br_pc,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] mtvec,
  input  logic [WIDTH-1:0] mepc,
  output logic [WIDTH-1:0] target,
  output logic             misalign
);
  localparam logic [WIDTH-1:0] CLR1 = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] CLR2 = {{(WIDTH-2){1'b1}}, 2'b00};
  logic [WIDTH-1:0] jalr_sum;
  assign jalr_sum = rs1 + imm;
  always_comb begin
    target = sel == SEL_BR   ? br_pc + imm :
             sel == SEL_JALR ? jalr_sum & CLR1 :
             sel == SEL_TRAP ? mtvec & CLR2 :
                               mepc & (C_EXT ? CLR1 : CLR2);
    // trap/mret targets are forced aligned, so only branch-type targets can fault
    misalign = !sel[0] && (target[0] || (!C_EXT && target[1]));
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with valid/ready offer, redirects, misalign parking and sticky halt
module pc_gen
  import pc_pkg::*;
#(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h8000_0000,
  parameter bit              C_EXT     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  pc_gen_if.master         bus,
  input  logic             halt_req,
  output logic             halted,
  output logic             misalign_valid,
  output logic [WIDTH-1:0] misalign_addr
);
  pc_state_e        state, state_n;
  logic [WIDTH-1:0] pc, pc_n, target, ma_n;
  logic             misalign, mv_n, fire, redir, halt_go;
  pc_target_calc #(.WIDTH(WIDTH), .C_EXT(C_EXT)) u_calc (
    .sel(bus.redirect_sel), .br_pc(bus.br_pc), .rs1(bus.rs1), .imm(bus.imm),
    .mtvec(bus.mtvec), .mepc(bus.mepc), .target(target), .misalign(misalign)
  );
  assign bus.out_valid = state == RUN;
  assign bus.out_pc    = pc;
  assign halted        = state == HALT;
  assign fire    = bus.out_valid && bus.out_ready;
  assign redir   = bus.redirect_valid && state inside {RUN, FLUSH, WAIT_TRAP};
  assign halt_go = halt_req && state != BOOT;
  always_comb begin
    state_n = (state == BOOT || state == FLUSH) ? RUN : state;
    pc_n    = fire ? pc + WIDTH'(C_EXT && bus.fetch_is16 ? 2 : 4) : pc;
    mv_n    = 1'b0;
    ma_n    = misalign_addr;
    if (halt_go) begin
      state_n = HALT;
      pc_n    = pc;
    end else if (redir) begin
      state_n = misalign ? WAIT_TRAP : FLUSH;
      pc_n    = misalign ? pc : target;
      mv_n    = misalign;
      ma_n    = misalign ? target : misalign_addr;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= BOOT;
      pc             <= RESET_VEC;
      misalign_valid <= 1'b0;
      misalign_addr  <= '0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      misalign_valid <= mv_n;
      misalign_addr  <= ma_n;
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed plus random checks of pc_gen (C_EXT=0 and C_EXT=1) against a behavioural model
module tb_pc_gen;
  localparam int M_BOOT = 0, M_RUN = 1, M_FLUSH = 2, M_WAIT = 3, M_HALT = 4;
  localparam logic [31:0] RV = 32'h8000_0000;
  logic clk = 0, rst = 1, ready = 0, is16 = 0, rv = 0, halt_req = 0;
  logic [1:0] sel = 0;
  logic [31:0] br_pc = 0, rs1 = 0, imm = 0, mtvec = 0, mepc = 0;
  logic halted0, halted1, mv0, mv1;
  logic [31:0] ma0, ma1;
  int errs = 0, checks = 0;
  int m_mode [2];
  logic [31:0] m_pc [2], m_ma [2];
  logic m_mv [2];
  pc_gen_if #(32) f0 ();
  pc_gen_if #(32) f1 ();
  assign f0.out_ready = ready;        assign f1.out_ready = ready;
  assign f0.fetch_is16 = is16;        assign f1.fetch_is16 = is16;
  assign f0.redirect_valid = rv;      assign f1.redirect_valid = rv;
  assign f0.redirect_sel = sel;       assign f1.redirect_sel = sel;
  assign f0.br_pc = br_pc;            assign f1.br_pc = br_pc;
  assign f0.rs1 = rs1;                assign f1.rs1 = rs1;
  assign f0.imm = imm;                assign f1.imm = imm;
  assign f0.mtvec = mtvec;            assign f1.mtvec = mtvec;
  assign f0.mepc = mepc;              assign f1.mepc = mepc;
  pc_gen #(.WIDTH(32), .RESET_VEC(RV), .C_EXT(1'b0)) u0 (
    .clk(clk), .rst(rst), .bus(f0), .halt_req(halt_req), .halted(halted0),
    .misalign_valid(mv0), .misalign_addr(ma0));
  pc_gen #(.WIDTH(32), .RESET_VEC(RV), .C_EXT(1'b1)) u1 (
    .clk(clk), .rst(rst), .bus(f1), .halt_req(halt_req), .halted(halted1),
    .misalign_valid(mv1), .misalign_addr(ma1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model(input int k);
    int unsigned al = (k == 1) ? 2 : 4;
    logic [31:0] t;
    if (rst) begin
      m_mode[k] = M_BOOT; m_pc[k] = RV; m_mv[k] = 0; m_ma[k] = 0;
    end else begin
      m_mv[k] = 0;
      if (m_mode[k] == M_BOOT) m_mode[k] = M_RUN;
      else if (m_mode[k] != M_HALT) begin
        if (halt_req) m_mode[k] = M_HALT;
        else if (rv) begin
          case (sel)
            2'b00: t = br_pc + imm;
            2'b10: begin t = rs1 + imm; t = t - t % 2; end
            2'b01: t = mtvec - mtvec % 4;
            default: t = mepc - mepc % al;
          endcase
          if (sel[0] == 1'b0 && t % al != 0) begin
            m_mv[k] = 1; m_ma[k] = t; m_mode[k] = M_WAIT;
          end else begin
            m_pc[k] = t; m_mode[k] = M_FLUSH;
          end
        end else if (m_mode[k] == M_RUN && ready) m_pc[k] = m_pc[k] + ((k == 1 && is16) ? 2 : 4);
        else if (m_mode[k] == M_FLUSH) m_mode[k] = M_RUN;
      end
    end
  endtask
  task automatic cyc();
    model(0);
    model(1);
    @(posedge clk);
    #1;
    chk("valid0", 32'(f0.out_valid), 32'(m_mode[0] == M_RUN));
    chk("pc0", f0.out_pc, m_pc[0]);
    chk("halted0", 32'(halted0), 32'(m_mode[0] == M_HALT));
    chk("mv0", 32'(mv0), 32'(m_mv[0]));
    chk("ma0", ma0, m_ma[0]);
    chk("valid1", 32'(f1.out_valid), 32'(m_mode[1] == M_RUN));
    chk("pc1", f1.out_pc, m_pc[1]);
    chk("halted1", 32'(halted1), 32'(m_mode[1] == M_HALT));
    chk("mv1", 32'(mv1), 32'(m_mv[1]));
    chk("ma1", ma1, m_ma[1]);
  endtask
  initial begin
    m_mode[0] = M_BOOT; m_mode[1] = M_BOOT;
    m_pc[0] = RV; m_pc[1] = RV; m_mv[0] = 0; m_mv[1] = 0; m_ma[0] = 0; m_ma[1] = 0;
    #2;
    repeat (3) cyc();
    chk("rst_valid", 32'(f0.out_valid), 32'd0);
    chk("rst_pc", f0.out_pc, RV);
    chk("rst_ma", ma0, 32'd0);
    rst = 0; ready = 1;
    cyc();
    chk("boot_valid", 32'(f0.out_valid), 32'd1);
    chk("boot_pc", f0.out_pc, 32'h8000_0000);
    cyc(); chk("seq_pc4", f0.out_pc, 32'h8000_0004);
    cyc(); chk("seq_pc8", f0.out_pc, 32'h8000_0008);
    cyc(); cyc();
    chk("pre_stall", f0.out_pc, 32'h8000_0010);
    ready = 0;
    repeat (4) cyc();
    chk("stall_pc", f0.out_pc, 32'h8000_0010);
    chk("stall_valid", 32'(f0.out_valid), 32'd1);
    ready = 1;
    cyc(); chk("unstall_pc", f0.out_pc, 32'h8000_0014);
    rv = 1; sel = 2'b00; br_pc = 32'h8000_0020; imm = 32'hFFFF_FFF0;
    cyc();
    chk("redir_valid", 32'(f0.out_valid), 32'd0);
    rv = 0;
    cyc();
    chk("redir_pc", f0.out_pc, 32'h8000_0010);
    chk("redir_valid2", 32'(f0.out_valid), 32'd1);
    rv = 1; sel = 2'b10; rs1 = 32'h8000_0102; imm = 0;
    cyc();
    chk("mis_pulse", 32'(mv0), 32'd1);
    chk("mis_addr", ma0, 32'h8000_0102);
    chk("mis_c_pc", f1.out_pc, 32'h8000_0102);
    rv = 0;
    cyc();
    chk("mis_drop", 32'(mv0), 32'd0);
    chk("mis_wait", 32'(f0.out_valid), 32'd0);
    cyc();
    rv = 1; sel = 2'b01; mtvec = 32'h8000_0203;
    cyc();
    rv = 0;
    cyc();
    chk("trap_pc", f0.out_pc, 32'h8000_0200);
    chk("trap_valid", 32'(f0.out_valid), 32'd1);
    rst = 1; cyc(); rst = 0; cyc();
    is16 = 1; cyc();
    chk("c16_pc", f1.out_pc, 32'h8000_0002);
    is16 = 0; cyc();
    chk("c32_pc", f1.out_pc, 32'h8000_0006);
    rv = 1; sel = 2'b00; br_pc = 32'hFFFF_FFF0; imm = 32'h0000_000C;
    cyc();
    rv = 0; ready = 0; cyc();
    chk("wrap_pre", f0.out_pc, 32'hFFFF_FFFC);
    ready = 1; cyc();
    chk("wrap_pc", f0.out_pc, 32'h0000_0000);
    chk("wrap_pc_c", f1.out_pc, 32'h0000_0000);
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom % 40) == 0;
      halt_req = ($urandom % 60) == 0;
      rv = ($urandom % 5) == 0;
      sel = 2'($urandom);
      br_pc = 32'h8000_0000 + ($urandom % 256);
      rs1 = $urandom;
      imm = 32'($urandom % 64) - 32'd32;
      mtvec = $urandom;
      mepc = $urandom;
      ready = ($urandom % 4) != 0;
      is16 = 1'($urandom);
      cyc();
    end
    rst = 1; halt_req = 0; rv = 0; ready = 1; is16 = 0;
    cyc();
    rst = 0; cyc();
    halt_req = 1; rv = 1; sel = 2'b01; mtvec = 32'h8000_0400;
    cyc();
    chk("halt_set", 32'(halted0), 32'd1);
    chk("halt_valid", 32'(f0.out_valid), 32'd0);
    chk("halt_pc", f0.out_pc, RV);
    halt_req = 0;
    cyc(); cyc();
    chk("halt_sticky", 32'(halted1), 32'd1);
    chk("halt_ignore", f1.out_pc, RV);
    rv = 0; rst = 1;
    cyc();
    chk("halt_rst", 32'(halted0), 32'd0);
    rst = 0;
    cyc();
    chk("halt_reboot", 32'(f0.out_valid), 32'd1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
